// File: rtl/mips_pkg.sv
// Shared mips32 datapath definitions: load/store opcodes, LSU state encoding
// and small decode helpers used by the memory-access stage.
package mips_pkg;

  localparam int XLEN    = 32;
  localparam int OP_W    = 6;
  localparam int REG_W   = 5;
  localparam int BE_W    = 4;
  localparam int WADDR_W = 30;

  localparam logic [OP_W-1:0] OP_LB  = 6'h20;
  localparam logic [OP_W-1:0] OP_LH  = 6'h21;
  localparam logic [OP_W-1:0] OP_LW  = 6'h23;
  localparam logic [OP_W-1:0] OP_LBU = 6'h24;
  localparam logic [OP_W-1:0] OP_LHU = 6'h25;
  localparam logic [OP_W-1:0] OP_SB  = 6'h28;
  localparam logic [OP_W-1:0] OP_SH  = 6'h29;
  localparam logic [OP_W-1:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} lsu_state_t;

  function automatic logic op_supported(input logic [OP_W-1:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: op_supported = 1'b1;
      default: op_supported = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_load(input logic [OP_W-1:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: op_is_load = 1'b1;
      default: op_is_load = 1'b0;
    endcase
  endfunction

  // Access size: 0 = byte, 1 = halfword, 2 = word
  function automatic logic [1:0] op_size(input logic [OP_W-1:0] op);
    case (op)
      OP_LH, OP_LHU, OP_SH: op_size = 2'd1;
      OP_LW, OP_SW:         op_size = 2'd2;
      default:              op_size = 2'd0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [OP_W-1:0] op, input logic [1:0] ea_lo);
    case (op_size(op))
      2'd1:    misaligned = ea_lo[0];
      2'd2:    misaligned = |ea_lo;
      default: misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [BE_W-1:0] lane_be(input logic [OP_W-1:0] op, input logic [1:0] ea_lo);
    case (op_size(op))
      2'd0:    lane_be = 4'b0001 << ea_lo;
      2'd1:    lane_be = 4'b0011 << ea_lo;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_rep(input logic [OP_W-1:0] op, input logic [XLEN-1:0] sd);
    case (op_size(op))
      2'd0:    store_rep = {4{sd[7:0]}};
      2'd1:    store_rep = {2{sd[15:0]}};
      default: store_rep = sd;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load-result extraction: picks the addressed lanes out of a
// little-endian word and sign/zero-extends them according to the opcode.
module load_align
  import mips_pkg::*;
(
  input  logic [OP_W-1:0] opcode_i,
  input  logic [1:0]      ea_lo_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] load_val_o
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata_i >> {ea_lo_i, 3'b000};

  always_comb begin
    case (opcode_i)
      OP_LB:   load_val_o = {{24{shifted[7]}}, shifted[7:0]};
      OP_LBU:  load_val_o = {24'd0, shifted[7:0]};
      OP_LH:   load_val_o = {{16{shifted[15]}}, shifted[15:0]};
      OP_LHU:  load_val_o = {16'd0, shifted[15:0]};
      default: load_val_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// mips32 memory-access stage: effective-address generation, a single
// variable-latency word access with timeout, and aligned load writeback.
module load_store_unit
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    opcode,
  input  logic [XLEN-1:0]    base,
  input  logic [XLEN-1:0]    store_data,
  input  logic [15:0]        imm,
  input  logic [REG_W-1:0]   rt_in,
  output logic               mem_req,
  output logic               mem_we,
  output logic [BE_W-1:0]    mem_be,
  output logic [WADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]    mem_wdata,
  input  logic [XLEN-1:0]    mem_rdata,
  input  logic               mem_ack,
  output logic               out_valid,
  output logic [XLEN-1:0]    write_data,
  output logic               signal_regWrite,
  output logic [REG_W-1:0]   wb_reg,
  output logic               addr_err,
  output logic               op_err,
  output logic               bus_err
);

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  lsu_state_t         state_q;
  logic [7:0]         cnt_q;
  logic [OP_W-1:0]    op_q;
  logic [1:0]         ea_lo_q;
  logic [REG_W-1:0]   rt_q;
  logic               mem_req_q, mem_we_q, out_valid_q, regwrite_q;
  logic               addr_err_q, op_err_q, bus_err_q;
  logic [BE_W-1:0]    mem_be_q;
  logic [WADDR_W-1:0] mem_addr_q;
  logic [XLEN-1:0]    mem_wdata_q, write_data_q;
  logic [REG_W-1:0]   wb_reg_q;

  logic [XLEN-1:0]    ea;
  logic               op_bad, ea_bad;
  logic [XLEN-1:0]    load_val;

  assign ea     = base + {{16{imm[15]}}, imm};
  assign op_bad = !op_supported(opcode);
  assign ea_bad = misaligned(opcode, ea[1:0]);

  load_align u_load_align (
    .opcode_i   (op_q),
    .ea_lo_i    (ea_lo_q),
    .rdata_i    (mem_rdata),
    .load_val_o (load_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      op_q         <= '0;
      ea_lo_q      <= 2'd0;
      rt_q         <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      out_valid_q  <= 1'b0;
      regwrite_q   <= 1'b0;
      write_data_q <= '0;
      wb_reg_q     <= '0;
      addr_err_q   <= 1'b0;
      op_err_q     <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q    <= opcode;
            ea_lo_q <= ea[1:0];
            rt_q    <= rt_in;
            if (op_bad || ea_bad) begin
              // Rejected requests complete next cycle without touching memory
              state_q      <= DONE;
              out_valid_q  <= 1'b1;
              op_err_q     <= op_bad;
              addr_err_q   <= !op_bad;
              bus_err_q    <= 1'b0;
              regwrite_q   <= 1'b0;
              write_data_q <= '0;
              wb_reg_q     <= rt_in;
            end else begin
              state_q     <= ACCESS;
              cnt_q       <= 8'd0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= !op_is_load(opcode);
              mem_be_q    <= lane_be(opcode, ea[1:0]);
              mem_addr_q  <= ea[31:2];
              mem_wdata_q <= op_is_load(opcode) ? '0 : store_rep(opcode, store_data);
            end
          end
        end
        ACCESS: begin
          if (mem_ack || cnt_q == TMO_LAST) begin
            state_q      <= DONE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            out_valid_q  <= 1'b1;
            op_err_q     <= 1'b0;
            addr_err_q   <= 1'b0;
            bus_err_q    <= !mem_ack;
            regwrite_q   <= mem_ack && op_is_load(op_q);
            write_data_q <= (mem_ack && op_is_load(op_q)) ? load_val : '0;
            wb_reg_q     <= rt_q;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready        = (state_q == IDLE);
  assign mem_req         = mem_req_q;
  assign mem_we          = mem_we_q;
  assign mem_be          = mem_be_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign out_valid       = out_valid_q;
  assign write_data      = write_data_q;
  assign signal_regWrite = regwrite_q;
  assign wb_reg          = wb_reg_q;
  assign addr_err        = addr_err_q;
  assign op_err          = op_err_q;
  assign bus_err         = bus_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, error paths, timeout
// and asynchronous reset during an access.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  opcode;
  logic [31:0] base;
  logic [31:0] store_data;
  logic [15:0] imm;
  logic [4:0]  rt_in;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        out_valid;
  logic [31:0] write_data;
  logic        signal_regWrite;
  logic [4:0]  wb_reg;
  logic        addr_err;
  logic        op_err;
  logic        bus_err;

  int checks   = 0;
  int failures = 0;

  load_store_unit #(.MEM_TIMEOUT(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .opcode          (opcode),
    .base            (base),
    .store_data      (store_data),
    .imm             (imm),
    .rt_in           (rt_in),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_be          (mem_be),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_ack         (mem_ack),
    .out_valid       (out_valid),
    .write_data      (write_data),
    .signal_regWrite (signal_regWrite),
    .wb_reg          (wb_reg),
    .addr_err        (addr_err),
    .op_err          (op_err),
    .bus_err         (bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request and returns in cycle T+1 (just after the accept edge)
  task automatic start_req(input logic [5:0] op, input logic [31:0] b, input logic [31:0] sd,
                           input logic [15:0] im, input logic [4:0] rt);
    opcode     = op;
    base       = b;
    store_data = sd;
    imm        = im;
    rt_in      = rt;
    in_valid   = 1'b1;
    tick();
    in_valid   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    opcode = '0; base = '0; store_data = '0; imm = '0; rt_in = '0;
    repeat (3) tick();
    checks++;
    if ({in_ready, mem_req, mem_we, out_valid, signal_regWrite, addr_err, op_err, bus_err} !== 8'b1000_0000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=10000000",
               {in_ready, mem_req, mem_we, out_valid, signal_regWrite, addr_err, op_err, bus_err});
    end
    checks++;
    if (mem_be !== 4'h0 || mem_addr !== 30'h0 || mem_wdata !== 32'h0 || write_data !== 32'h0 || wb_reg !== 5'h0) begin
      failures++;
      $display("FAIL reset_data be=%h addr=%h wdata=%h wd=%h wb=%h want all zero",
               mem_be, mem_addr, mem_wdata, write_data, wb_reg);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_lw();
    start_req(6'h23, 32'h100, 32'h0, 16'h0004, 5'd9);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'hF || mem_addr !== 30'h41 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL lw_req req=%b we=%b be=%h addr=%h rdy=%b want 1 0 f 41 0", mem_req, mem_we, mem_be, mem_addr, in_ready);
    end
    base = 32'hFFFF_0000;
    tick();
    tick();
    checks++;
    if (mem_addr !== 30'h41 || mem_req !== 1'b1) begin
      failures++;
      $display("FAIL lw_addr_stable addr=%h req=%b want 41 1", mem_addr, mem_req);
    end
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL lw_early_valid got=%b want 0", out_valid);
    end
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    checks++;
    if (out_valid !== 1'b1 || write_data !== 32'hDEADBEEF || signal_regWrite !== 1'b1 || wb_reg !== 5'd9 ||
        mem_req !== 1'b0 || {addr_err, op_err, bus_err} !== 3'b000 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL lw_done ov=%b wd=%h rw=%b wb=%0d req=%b err=%b rdy=%b want 1 deadbeef 1 9 0 000 0",
               out_valid, write_data, signal_regWrite, wb_reg, mem_req, {addr_err, op_err, bus_err}, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || write_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL lw_after ov=%b rdy=%b wd=%h want 0 1 deadbeef", out_valid, in_ready, write_data);
    end
  endtask

  // Minimum-latency loads (ack in the first request cycle)
  task automatic test_sub_word_loads();
    logic [5:0]  ops  [6] = '{6'h20, 6'h24, 6'h21, 6'h25, 6'h23, 6'h21};
    logic [31:0] bases[6] = '{32'h100, 32'h100, 32'h10, 32'h10, 32'h0, 32'h7FFF_FFF0};
    logic [15:0] imms [6] = '{16'h0003, 16'h0003, 16'hFFF2, 16'hFFF2, 16'hFFFC, 16'h0010};
    logic [31:0] words[6] = '{32'h80FF7F01, 32'h80FF7F01, 32'h80011234, 32'h80011234, 32'hCAFEF00D, 32'h00007FFF};
    logic [3:0]  exp_be[6] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b1111, 4'b0011};
    logic [29:0] exp_ad[6] = '{30'h40, 30'h40, 30'h0, 30'h0, 30'h3FFFFFFF, 30'h20000000};
    logic [31:0] exp_wd[6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001, 32'hCAFEF00D, 32'h00007FFF};
    for (int i = 0; i < 6; i++) begin
      start_req(ops[i], bases[i], 32'h0, imms[i], 5'(i + 3));
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_be !== exp_be[i] || mem_addr !== exp_ad[i]) begin
        failures++;
        $display("FAIL load%0d_req req=%b we=%b be=%b addr=%h want 1 0 %b %h",
                 i, mem_req, mem_we, mem_be, mem_addr, exp_be[i], exp_ad[i]);
      end
      mem_ack = 1'b1; mem_rdata = words[i];
      tick();
      mem_ack = 1'b0; mem_rdata = 32'h0;
      checks++;
      if (out_valid !== 1'b1 || write_data !== exp_wd[i] || signal_regWrite !== 1'b1 || wb_reg !== 5'(i + 3)) begin
        failures++;
        $display("FAIL load%0d_done ov=%b wd=%h rw=%b wb=%0d want 1 %h 1 %0d",
                 i, out_valid, write_data, signal_regWrite, wb_reg, exp_wd[i], i + 3);
      end
      tick();
    end
  endtask

  task automatic test_stores();
    logic [5:0]  ops  [3] = '{6'h29, 6'h28, 6'h2B};
    logic [15:0] imms [3] = '{16'h0002, 16'h0001, 16'h0004};
    logic [3:0]  exp_be[3] = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] exp_wd[3] = '{32'hABCDABCD, 32'hCDCDCDCD, 32'h1234ABCD};
    for (int i = 0; i < 3; i++) begin
      start_req(ops[i], 32'h200, 32'h1234ABCD, imms[i], 5'd17);
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== exp_be[i] || mem_wdata !== exp_wd[i]) begin
        failures++;
        $display("FAIL store%0d_req req=%b we=%b be=%b wdata=%h want 1 1 %b %h",
                 i, mem_req, mem_we, mem_be, mem_wdata, exp_be[i], exp_wd[i]);
      end
      tick();
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || signal_regWrite !== 1'b0 || mem_req !== 1'b0 || {addr_err, op_err, bus_err} !== 3'b000) begin
        failures++;
        $display("FAIL store%0d_done ov=%b rw=%b req=%b err=%b want 1 0 0 000",
                 i, out_valid, signal_regWrite, mem_req, {addr_err, op_err, bus_err});
      end
      tick();
    end
  endtask

  task automatic test_errors();
    logic [5:0]  ops  [4] = '{6'h23, 6'h3F, 6'h3F, 6'h25};
    logic [15:0] imms [4] = '{16'h0002, 16'h0000, 16'h0001, 16'h0003};
    logic [2:0]  exp_err[4] = '{3'b100, 3'b010, 3'b010, 3'b100};
    for (int i = 0; i < 4; i++) begin
      start_req(ops[i], 32'h100, 32'h0, imms[i], 5'd21);
      checks++;
      if (mem_req !== 1'b0 || out_valid !== 1'b1 || {addr_err, op_err, bus_err} !== exp_err[i] ||
          signal_regWrite !== 1'b0 || wb_reg !== 5'd21) begin
        failures++;
        $display("FAIL err%0d req=%b ov=%b err=%b rw=%b wb=%0d want 0 1 %b 0 21",
                 i, mem_req, out_valid, {addr_err, op_err, bus_err}, exp_err[i], signal_regWrite, wb_reg);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || mem_req !== 1'b0) begin
        failures++;
        $display("FAIL err%0d_after ov=%b rdy=%b req=%b want 0 1 0", i, out_valid, in_ready, mem_req);
      end
    end
  endtask

  task automatic test_timeout();
    start_req(6'h2B, 32'h300, 32'h55AA55AA, 16'h0000, 5'd2);
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (mem_req !== 1'b1 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL tmo_req_c%0d req=%b ov=%b want 1 0", c, mem_req, out_valid);
      end
      tick();
    end
    checks++;
    if (mem_req !== 1'b0 || out_valid !== 1'b1 || {addr_err, op_err, bus_err} !== 3'b001 || signal_regWrite !== 1'b0) begin
      failures++;
      $display("FAIL tmo_done req=%b ov=%b err=%b rw=%b want 0 1 001 0",
               mem_req, out_valid, {addr_err, op_err, bus_err}, signal_regWrite);
    end
    tick();
  endtask

  task automatic test_reset_mid_access();
    start_req(6'h23, 32'h400, 32'h0, 16'h0000, 5'd4);
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid req=%b rdy=%b want 0 1", mem_req, in_ready);
    end
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    tick();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || mem_req !== 1'b0 || in_ready !== 1'b1 || write_data !== 32'h0) begin
      failures++;
      $display("FAIL rst_late_ack ov=%b req=%b rdy=%b wd=%h want 0 0 1 0", out_valid, mem_req, in_ready, write_data);
    end
    mem_ack = 1'b0; mem_rdata = 32'h0;
    tick();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sub_word_loads();
    test_stores();
    test_errors();
    test_timeout();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the mips32 load/store datapath. It sits between operand read and register writeback. It takes the base register, store data and immediate for one load/store instruction, computes the effective address and runs a variable-latency word access to data memory. It then hands the aligned, extended load result to the register-file write port.

## Interface
Parameters:
- MEM_TIMEOUT, 255, max cycles `mem_req` may wait for `mem_ack` before abort (1..255).

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  instruction request valid
- in_ready  out  1  unit can accept a request
- opcode  in  6  MIPS opcode
- base  in  32  rs value (register-file `read_data_1`)
- store_data  in  32  rt value (register-file `read_data_2`)
- imm  in  16  offset, sign-extended internally
- rt_in  in  5  destination/source register number
- mem_req  out  1  memory access request, held until ack
- mem_we  out  1  1 = write
- mem_be  out  4  byte enables, bit i = byte lane i
- mem_addr  out  30  word address (effective address [31:2])
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  read word, valid when `mem_ack`=1
- mem_ack  in  1  access complete
- out_valid  out  1  one-cycle completion pulse
- write_data  out  32  load result for the register file
- signal_regWrite  out  1  writeback enable (loads only, no error)
- wb_reg  out  5  register to write (= captured `rt_in`)
- addr_err  out  1  misaligned address (with `out_valid`)
- op_err  out  1  unsupported opcode (with `out_valid`)
- bus_err  out  1  memory timeout (with `out_valid`)

## Operation
- Supported opcodes:
  - 0x20 lb, 0x21 lh, 0x23 lw
  - 0x24 lbu, 0x25 lhu
  - 0x28 sb, 0x29 sh, 0x2B sw
- Effective address: EA = `base` + sign-extended `imm`, mod 2^32. Wrap-around is silent.
- Byte order is little-endian: byte at EA[1:0]=k is lane k.
- Alignment:
  - Halfword ops need EA[0]=0.
  - Word ops need EA[1:0]=0.
  - A violation sets `addr_err` and makes no memory access.
- Stores:
  - sb: `mem_be`=1<<EA[1:0], `mem_wdata`={4{sd[7:0]}}.
  - sh: `mem_be`=4'b0011<<EA[1:0], `mem_wdata`={2{sd[15:0]}}.
  - sw: `mem_be`=4'hF.
- Loads:
  - `mem_be` selects the accessed lanes, `mem_we`=0.
  - The result is extracted from the selected lanes.
  - lb/lh sign-extend; lbu/lhu zero-extend.
- FSM:
  - IDLE: `in_ready`=1. On `in_valid`, latch all inputs.
    - Error case (bad opcode or misaligned): go to DONE with the error flag.
    - Otherwise go to ACCESS.
  - ACCESS: `mem_req`=1 with stable address, data and enables; count cycles.
    - On `mem_ack`, capture `mem_rdata` and go to DONE.
    - When the count reaches MEM_TIMEOUT without ack, set `bus_err` and go to DONE.
  - DONE: `out_valid`=1 for one cycle, then return to IDLE.
    - `signal_regWrite`=1 only for a load with no error flag.
- Priority: `op_err` over `addr_err`. Only one error flag is ever set.
- `mem_ack` outside ACCESS is ignored.
- Reset values:
  - FSM to IDLE; counter to 0.
  - `in_ready`=1.
  - `mem_req`, `mem_we`, `out_valid`, `signal_regWrite` and all error flags = 0.
  - `mem_be`=0, `mem_addr`=0, `mem_wdata`=0, `write_data`=0, `wb_reg`=0.
- Reset mid-access drops `mem_req` immediately (asynchronous). A late `mem_ack` is ignored.

## Timing
- Request is accepted at the edge where `in_valid` & `in_ready` are both high (cycle T).
- `mem_req` is asserted from T+1.
- Ack in cycle T+1+n gives `out_valid` at T+2+n. Minimum latency is 2 cycles.
- Error requests: `out_valid` at T+1, with no `mem_req`.
- A timeout asserts `mem_req` for exactly MEM_TIMEOUT cycles, then `out_valid`+`bus_err` on the next cycle.
- `in_ready`=0 from T+1 until the cycle after `out_valid`. Throughput is at most one op per 3 cycles.
- `write_data`, `wb_reg` and the flags are registered and hold until the next completion.
- `out_valid` has no backpressure; the register file always accepts.

## Structure
- Shared package `mips_pkg`:
  - opcode localparams (OP_LB..OP_SW)
  - the `lsu_state_t` enum (IDLE, ACCESS, DONE)
  - width constants
- One sub-module: `load_align`.
  - Combinational.
  - Inputs: opcode, EA[1:0], raw word.
  - Output: 32-bit extended load value.
  - Reused later by the cache path.

## Test plan
- lw: `base`=0x100, `imm`=0x0004, `mem_rdata`=0xDEADBEEF, ack after 3 cycles -> `mem_addr`=0x41, `mem_be`=F; `out_valid` 5 cycles after accept; `write_data`=0xDEADBEEF, `signal_regWrite`=1.
- lb/lbu: EA=0x103, word 0x80FF7F01 -> lb 0xFFFFFF80, lbu 0x00000080, `mem_be`=4'b1000.
- sh: EA=0x202, `store_data`=0x1234ABCD -> `mem_we`=1, `mem_be`=4'b1100, `mem_wdata`=0xABCDABCD; `out_valid` with `signal_regWrite`=0.
- Misaligned lw at EA=0x102 -> no `mem_req`, `out_valid`+`addr_err` at T+1; opcode 0x3F -> `op_err` only.
- Never-ack with MEM_TIMEOUT=4 -> `mem_req` high 4 cycles, then `bus_err`; `rst` mid-ACCESS -> `mem_req` low immediately, `in_ready`=1.
